ahb_master_arb: RTL and testbench

- AHB bus arbiter and master mux that lets NUM_MST bus masters (core model, DMA, test masters) share one AHB interconnect port.
- Uses an AHB request/grant handshake: the masters request the bus, the arbiter grants one, re-arbitrates only at burst or lock boundaries, and muxes address, control and write data onto the single slave-side port.

---
 rtl/ahb_master_arb.sv | 237 +++++++++++++++++++++++
 tb/tb_ahb_master_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arb.sv
// AHB arbiter and master mux: NUM_MST masters share one slave-side AHB port.
// Grant changes only at arbitration points (idle, last beat of a fixed burst,
// or end of an open INCR), never while the address-phase owner is locked.
// The grant is presented combinationally in the arbitration cycle so the new
// owner drives the very next address phase with no IDLE bubble.
// Optional build macro: ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of round-robin.
module ahb_master_arb #(
  parameter int unsigned NUM_MST      = 2,
  parameter int unsigned HADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned HBURST_WIDTH = 3
) (
  input  logic                                  hclk,
  input  logic                                  hresetn,
  input  logic [NUM_MST-1:0]                    m_hbusreq,
  input  logic [NUM_MST-1:0]                    m_hlock,
  output logic [NUM_MST-1:0]                    m_hgrant,
  input  logic [NUM_MST*HADDR_WIDTH-1:0]        m_haddr,
  input  logic [NUM_MST*2-1:0]                  m_htrans,
  input  logic [NUM_MST-1:0]                    m_hwrite,
  input  logic [NUM_MST*3-1:0]                  m_hsize,
  input  logic [NUM_MST*HBURST_WIDTH-1:0]       m_hburst,
  input  logic [NUM_MST*DATA_WIDTH-1:0]         m_hwdata,
  input  logic [NUM_MST*(DATA_WIDTH/8)-1:0]     m_hwstrb,
  output logic [HADDR_WIDTH-1:0]                haddr,
  output logic [1:0]                            htrans,
  output logic                                  hwrite,
  output logic [2:0]                            hsize,
  output logic [HBURST_WIDTH-1:0]               hburst,
  output logic                                  hmasterlock,
  output logic [DATA_WIDTH-1:0]                 hwdata,
  output logic [DATA_WIDTH/8-1:0]               hwstrb,
  output logic [2:0]                            hmaster,
  input  logic                                  hready,
  input  logic                                  hresp,
  input  logic [DATA_WIDTH-1:0]                 hrdata,
  output logic                                  m_hready,
  output logic                                  m_hresp,
  output logic [DATA_WIDTH-1:0]                 m_hrdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } hburst_e;

  // Per-master slices padded to 8 entries so the 3-bit owner index selects exactly.
  logic [HADDR_WIDTH-1:0]  addr_a  [8];
  logic [1:0]              trans_a [8];
  logic                    write_a [8];
  logic [2:0]              size_a  [8];
  logic [HBURST_WIDTH-1:0] burst_a [8];
  logic [DATA_WIDTH-1:0]   wdata_a [8];
  logic [STRB_W-1:0]       wstrb_a [8];
  logic [7:0]              req8;
  logic [7:0]              lock8;

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NUM_MST) begin : g_m
      assign addr_a[g]  = m_haddr[g*HADDR_WIDTH +: HADDR_WIDTH];
      assign trans_a[g] = m_htrans[g*2 +: 2];
      assign write_a[g] = m_hwrite[g];
      assign size_a[g]  = m_hsize[g*3 +: 3];
      assign burst_a[g] = m_hburst[g*HBURST_WIDTH +: HBURST_WIDTH];
      assign wdata_a[g] = m_hwdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign wstrb_a[g] = m_hwstrb[g*STRB_W +: STRB_W];
    end else begin : g_z
      assign addr_a[g]  = '0;
      assign trans_a[g] = '0;
      assign write_a[g] = 1'b0;
      assign size_a[g]  = '0;
      assign burst_a[g] = '0;
      assign wdata_a[g] = '0;
      assign wstrb_a[g] = '0;
    end
  end

  assign req8  = 8'(m_hbusreq);
  assign lock8 = 8'(m_hlock);

  logic [NUM_MST-1:0] grant_q;
  logic [2:0]         addr_owner;
  logic [2:0]         data_owner;
  logic [4:0]         cnt_q;
  logic               open_q;
`ifndef ARB_FIXED_PRIO_EN
  logic [2:0]         rr_ptr;
`endif

  htrans_e            cur_trans;
  hburst_e            cur_burst;
  logic               own_lock;
  logic               own_req;
  logic [4:0]         cnt_nxt;
  logic               open_nxt;
  logic               last_beat;
  logic               open_end;
  logic               arb_pt;
  logic [2:0]         win;
  logic               found;
  logic [NUM_MST-1:0] nxt_grant;
  logic [2:0]         grant_idx;

  assign cur_trans = htrans_e'(trans_a[addr_owner]);
  assign cur_burst = hburst_e'(burst_a[addr_owner][2:0]);
  assign own_lock  = lock8[addr_owner];
  assign own_req   = req8[addr_owner];

  // Slave-side mux: address/control from the address owner, write data from the data owner.
  assign haddr       = addr_a[addr_owner];
  assign htrans      = trans_a[addr_owner];
  assign hwrite      = write_a[addr_owner];
  assign hsize       = size_a[addr_owner];
  assign hburst      = burst_a[addr_owner];
  assign hmasterlock = own_lock;
  assign hmaster     = addr_owner;
  assign hwdata      = wdata_a[data_owner];
  assign hwstrb      = wstrb_a[data_owner];

  assign m_hready = hready;
  assign m_hresp  = hresp;
  assign m_hrdata = hrdata;

  // Beat counter next value for the transfer currently in the address phase.
  always_comb begin
    cnt_nxt  = cnt_q;
    open_nxt = open_q;
    case (cur_trans)
      TR_IDLE: begin
        cnt_nxt  = '0;
        open_nxt = 1'b0;
      end
      TR_NONSEQ: begin
        open_nxt = (cur_burst == BU_INCR);
        case (cur_burst)
          BU_WRAP4,  BU_INCR4:  cnt_nxt = 5'd3;
          BU_WRAP8,  BU_INCR8:  cnt_nxt = 5'd7;
          BU_WRAP16, BU_INCR16: cnt_nxt = 5'd15;
          default:              cnt_nxt = '0;
        endcase
      end
      TR_SEQ: begin
        if (!open_q && cnt_q != '0) cnt_nxt = cnt_q - 5'd1;
      end
      default: ;
    endcase
  end

  // Arbitration point: hready, owner unlocked, and a burst/idle boundary reached.
  always_comb begin
    last_beat = ((cur_trans == TR_NONSEQ) || (cur_trans == TR_SEQ)) &&
                !open_nxt && (cnt_nxt == '0);
    open_end  = open_nxt && !own_req;
    arb_pt    = hresetn && hready && !own_lock &&
                ((cur_trans == TR_IDLE) || last_beat || open_end);
  end

  // Winner selection; with no requests the winner defaults to master 0 (parking).
  always_comb begin
    win   = '0;
    found = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && req8[i]) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
`else
    // Two passes implement the wrap: first above the pointer, then from 0.
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && req8[i] && (3'(i) > rr_ptr)) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && req8[i]) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
`endif
  end

  // One-hot grant: new winner during an arbitration point, otherwise held.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MST; i++) nxt_grant[i] = (win == 3'(i));
    m_hgrant  = arb_pt ? nxt_grant : grant_q;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      if (m_hgrant[i]) grant_idx = 3'(i);
    end
  end

  // Ownership pipeline, beat state, grant and pointer registers.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      grant_q    <= {{(NUM_MST-1){1'b0}}, 1'b1};
      addr_owner <= '0;
      data_owner <= '0;
      cnt_q      <= '0;
      open_q     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
    end else begin
      grant_q <= m_hgrant;
      if (hready) begin
        addr_owner <= grant_idx;
        data_owner <= addr_owner;
        cnt_q      <= cnt_nxt;
        open_q     <= open_nxt;
      end
`ifndef ARB_FIXED_PRIO_EN
      if (arb_pt && found) rr_ptr <= win;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_master_arb.sv
// Directed bench for ahb_master_arb with two masters: a vector table for the
// basic handover / round-robin cases plus hand-written multi-cycle sequences
// for lock, hready stalls, error response and reset during a burst.
module tb_ahb_master_arb;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 3;

  localparam logic [1:0] TI = 2'd0;
  localparam logic [1:0] TN = 2'd2;
  localparam logic [1:0] TS = 2'd3;
  localparam logic [2:0] BS  = 3'd0;
  localparam logic [2:0] BW4 = 3'd2;
  localparam logic [2:0] BI4 = 3'd3;

  localparam logic [31:0] D0 = 32'hA0A0_0A0A;
  localparam logic [31:0] D1 = 32'hB1B1_1B1B;
  localparam logic [3:0]  S0 = 4'h3;
  localparam logic [3:0]  S1 = 4'hC;

  logic                 hclk = 1'b0;
  logic                 hresetn;
  logic [NM-1:0]        m_hbusreq, m_hlock, m_hgrant, m_hwrite;
  logic [NM*AW-1:0]     m_haddr;
  logic [NM*2-1:0]      m_htrans;
  logic [NM*3-1:0]      m_hsize;
  logic [NM*BW-1:0]     m_hburst;
  logic [NM*DW-1:0]     m_hwdata;
  logic [NM*DW/8-1:0]   m_hwstrb;
  logic [AW-1:0]        haddr;
  logic [1:0]           htrans;
  logic                 hwrite, hmasterlock, hready, hresp, m_hready, m_hresp;
  logic [2:0]           hsize, hmaster;
  logic [BW-1:0]        hburst;
  logic [DW-1:0]        hwdata, hrdata, m_hrdata;
  logic [DW/8-1:0]      hwstrb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 hclk = ~hclk;

  ahb_master_arb #(.NUM_MST(NM), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .HBURST_WIDTH(BW)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m_hbusreq(m_hbusreq), .m_hlock(m_hlock), .m_hgrant(m_hgrant),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hwstrb(m_hwstrb),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hmasterlock(hmasterlock), .hwdata(hwdata), .hwstrb(hwstrb), .hmaster(hmaster),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  t0;
    logic [2:0]  b0;
    logic [31:0] a0;
    logic [1:0]  t1;
    logic [2:0]  b1;
    logic [31:0] a1;
    logic [1:0]  e_gnt;
    logic [2:0]  e_hm;
    logic [1:0]  e_ht;
    logic [31:0] e_ha;
    logic        e_wd;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic [1:0] req,
                              input logic [1:0] t0, input logic [2:0] b0, input logic [31:0] a0,
                              input logic [1:0] t1, input logic [2:0] b1, input logic [31:0] a1,
                              input logic [1:0] eg, input logic [2:0] ehm, input logic [1:0] eht,
                              input logic [31:0] eha, input logic ewd);
    vec_t v;
    v.rst = rst; v.req = req; v.t0 = t0; v.b0 = b0; v.a0 = a0;
    v.t1 = t1; v.b1 = b1; v.a1 = a1;
    v.e_gnt = eg; v.e_hm = ehm; v.e_ht = eht; v.e_ha = eha; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] lck,
                       input logic [1:0] t0, input logic [2:0] b0, input logic [31:0] a0,
                       input logic [1:0] t1, input logic [2:0] b1, input logic [31:0] a1,
                       input logic rdy, input logic resp, input logic [31:0] rd);
    @(negedge hclk);
    hresetn   = rst;
    m_hbusreq = req;
    m_hlock   = lck;
    m_htrans  = {t1, t0};
    m_hburst  = {b1, b0};
    m_haddr   = {a1, a0};
    hready    = rdy;
    hresp     = resp;
    hrdata    = rd;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    hresetn = 1'b0; m_hbusreq = '0; m_hlock = '0; m_htrans = '0; m_hburst = '0;
    m_haddr = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    m_hwrite = 2'b01; m_hsize = {3'd2, 3'd2};
    m_hwdata = {D1, D0}; m_hwstrb = {S1, S0};

    // Reset, idle parking, master 1 handover, INCR4 boundary, SINGLE rotation.
    tbl[0]  = mk(1'b0, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,      2'b01, 3'd0, TI, 32'h0, 1'b0);
    tbl[1]  = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,      2'b01, 3'd0, TI, 32'h0, 1'b0);
    tbl[2]  = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,      2'b01, 3'd0, TI, 32'h0, 1'b0);
    tbl[3]  = mk(1'b1, 2'b10, TI, BS, 32'h0, TI, BS, 32'h0,      2'b10, 3'd0, TI, 32'h0, 1'b0);
    tbl[4]  = mk(1'b1, 2'b10, TI, BS, 32'h0, TN, BS, 32'h1000,   2'b10, 3'd1, TN, 32'h1000, 1'b0);
    tbl[5]  = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,      2'b01, 3'd1, TI, 32'h0, 1'b1);
    tbl[6]  = mk(1'b1, 2'b01, TI, BS, 32'h0, TI, BS, 32'h0,      2'b01, 3'd0, TI, 32'h0, 1'b1);
    tbl[7]  = mk(1'b1, 2'b11, TN, BI4, 32'h4003_0000, TI, BS, 32'h0, 2'b01, 3'd0, TN, 32'h4003_0000, 1'b0);
    tbl[8]  = mk(1'b1, 2'b11, TS, BI4, 32'h4003_0004, TI, BS, 32'h0, 2'b01, 3'd0, TS, 32'h4003_0004, 1'b0);
    tbl[9]  = mk(1'b1, 2'b11, TS, BI4, 32'h4003_0008, TI, BS, 32'h0, 2'b01, 3'd0, TS, 32'h4003_0008, 1'b0);
    tbl[10] = mk(1'b1, 2'b11, TS, BI4, 32'h4003_000C, TI, BS, 32'h0, 2'b10, 3'd0, TS, 32'h4003_000C, 1'b0);
    tbl[11] = mk(1'b1, 2'b10, TI, BS, 32'h0, TN, BS, 32'h2000,   2'b10, 3'd1, TN, 32'h2000, 1'b0);
    tbl[12] = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,      2'b01, 3'd1, TI, 32'h0, 1'b1);
    tbl[13] = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,      2'b01, 3'd0, TI, 32'h0, 1'b1);
`ifdef ARB_FIXED_PRIO_EN
    tbl[14] = mk(1'b1, 2'b11, TN, BS, 32'h100, TN, BS, 32'h200, 2'b01, 3'd0, TN, 32'h100, 1'b0);
    tbl[15] = mk(1'b1, 2'b11, TN, BS, 32'h100, TN, BS, 32'h200, 2'b01, 3'd0, TN, 32'h100, 1'b0);
    tbl[16] = mk(1'b1, 2'b11, TN, BS, 32'h100, TN, BS, 32'h200, 2'b01, 3'd0, TN, 32'h100, 1'b0);
    tbl[17] = mk(1'b1, 2'b11, TN, BS, 32'h100, TN, BS, 32'h200, 2'b01, 3'd0, TN, 32'h100, 1'b0);
    tbl[18] = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,     2'b01, 3'd0, TI, 32'h0, 1'b0);
    tbl[19] = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,     2'b01, 3'd0, TI, 32'h0, 1'b0);
`else
    tbl[14] = mk(1'b1, 2'b11, TN, BS, 32'h100, TN, BS, 32'h200, 2'b01, 3'd0, TN, 32'h100, 1'b0);
    tbl[15] = mk(1'b1, 2'b11, TN, BS, 32'h100, TN, BS, 32'h200, 2'b10, 3'd0, TN, 32'h100, 1'b0);
    tbl[16] = mk(1'b1, 2'b11, TN, BS, 32'h100, TN, BS, 32'h200, 2'b01, 3'd1, TN, 32'h200, 1'b0);
    tbl[17] = mk(1'b1, 2'b11, TN, BS, 32'h100, TN, BS, 32'h200, 2'b10, 3'd0, TN, 32'h100, 1'b1);
    tbl[18] = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,     2'b01, 3'd1, TI, 32'h0, 1'b0);
    tbl[19] = mk(1'b1, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0,     2'b01, 3'd0, TI, 32'h0, 1'b1);
`endif

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].rst, tbl[k].req, 2'b00, tbl[k].t0, tbl[k].b0, tbl[k].a0,
            tbl[k].t1, tbl[k].b1, tbl[k].a1, 1'b1, 1'b0, 32'h5A5A_0000 + 32'(k));
      chk($sformatf("v%0d grant", k),   32'(m_hgrant), 32'(tbl[k].e_gnt));
      chk($sformatf("v%0d hmaster", k), 32'(hmaster),  32'(tbl[k].e_hm));
      chk($sformatf("v%0d htrans", k),  32'(htrans),   32'(tbl[k].e_ht));
      chk($sformatf("v%0d haddr", k),   haddr,         tbl[k].e_ha);
      chk($sformatf("v%0d hwrite", k),  32'(hwrite),   32'(tbl[k].e_hm == 3'd0));
      chk($sformatf("v%0d hwdata", k),  hwdata,        tbl[k].e_wd ? D1 : D0);
      chk($sformatf("v%0d hwstrb", k),  32'(hwstrb),   32'(tbl[k].e_wd ? S1 : S0));
      chk($sformatf("v%0d m_hrdata", k), m_hrdata,     32'h5A5A_0000 + 32'(k));
    end

    // Master 0 locked for 20 cycles while master 1 requests.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'b11, 2'b01, (i % 2 == 1) ? TN : TI, BS, 32'h900, TI, BS, 32'h0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("lock%0d grant", i), 32'(m_hgrant), 32'h1);
      chk($sformatf("lock%0d hmasterlock", i), 32'(hmasterlock), 32'h1);
    end
    drive(1'b1, 2'b10, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("unlock grant", 32'(m_hgrant), 32'h2);
    chk("unlock hmasterlock", 32'(hmasterlock), 32'h0);

    // WRAP4 by master 1 with a 3-cycle hready stall on beat 3.
    drive(1'b1, 2'b10, 2'b00, TI, BS, 32'h0, TN, BW4, 32'h3008, 1'b1, 1'b0, 32'h0);
    chk("wrap b1 hmaster", 32'(hmaster), 32'h1);
    chk("wrap b1 grant", 32'(m_hgrant), 32'h2);
    drive(1'b1, 2'b10, 2'b00, TI, BS, 32'h0, TS, BW4, 32'h300C, 1'b1, 1'b0, 32'h0);
    chk("wrap b2 grant", 32'(m_hgrant), 32'h2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 2'b00, TI, BS, 32'h0, TS, BW4, 32'h3000, 1'b0, 1'b0, 32'h0);
      chk($sformatf("stall%0d haddr", i), haddr, 32'h3000);
      chk($sformatf("stall%0d grant", i), 32'(m_hgrant), 32'h2);
      chk($sformatf("stall%0d hmaster", i), 32'(hmaster), 32'h1);
    end
    drive(1'b1, 2'b11, 2'b00, TI, BS, 32'h0, TS, BW4, 32'h3000, 1'b1, 1'b0, 32'h0);
    chk("wrap b3 grant", 32'(m_hgrant), 32'h2);
    drive(1'b1, 2'b11, 2'b00, TI, BS, 32'h0, TS, BW4, 32'h3004, 1'b1, 1'b0, 32'h0);
    chk("wrap b4 haddr", haddr, 32'h3004);
    chk("wrap b4 grant", 32'(m_hgrant), 32'h1);
    drive(1'b1, 2'b01, 2'b00, TN, BS, 32'h500, TI, BS, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("after wrap hmaster", 32'(hmaster), 32'h0);
    chk("after wrap haddr", haddr, 32'h500);

    // Error response in master 0's INCR4: owner goes IDLE, next ready cycle re-arbitrates.
    drive(1'b1, 2'b11, 2'b00, TN, BI4, 32'h600, TI, BS, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("err start grant", 32'(m_hgrant), 32'h1);
    drive(1'b1, 2'b10, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0, 1'b0, 1'b1, 32'hDEAD_0001);
    chk("err1 grant", 32'(m_hgrant), 32'h1);
    chk("err1 m_hresp", 32'(m_hresp), 32'h1);
    chk("err1 m_hready", 32'(m_hready), 32'h0);
    drive(1'b1, 2'b10, 2'b00, TI, BS, 32'h0, TI, BS, 32'h0, 1'b1, 1'b1, 32'h0);
    chk("err2 grant", 32'(m_hgrant), 32'h2);
    drive(1'b1, 2'b10, 2'b00, TI, BS, 32'h0, TN, BS, 32'h700, 1'b1, 1'b0, 32'h0);
    chk("err next hmaster", 32'(hmaster), 32'h1);
    chk("err next haddr", haddr, 32'h700);

    // Reset during master 1's INCR4.
    drive(1'b1, 2'b10, 2'b00, TI, BS, 32'h0, TN, BI4, 32'h800, 1'b1, 1'b0, 32'h0);
    chk("pre-rst hmaster", 32'(hmaster), 32'h1);
    drive(1'b0, 2'b10, 2'b00, TI, BS, 32'h0, TS, BI4, 32'h804, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 2'b00, 2'b00, TI, BS, 32'h0, TS, BI4, 32'h808, 1'b1, 1'b0, 32'h0);
    chk("post-rst hmaster", 32'(hmaster), 32'h0);
    chk("post-rst htrans", 32'(htrans), 32'(TI));
    chk("post-rst grant", 32'(m_hgrant), 32'h1);
    chk("post-rst hwdata", hwdata, D0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
